// File: rtl/rr_burst_arbiter_if.sv
// Handshake bundle between four requesters, the round-robin arbiter and
// the downstream consumer. The arbiter connects through the slave modport.
interface rr_burst_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_ready;
    logic            busy;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, busy
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Four-way round-robin arbiter with burst locking. A winner keeps the
// grant for up to MAX_BURST consecutive beats, or until it drops valid.
// The output stage is a single register slice that can be stalled by
// out_ready.
module rr_burst_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    rr_burst_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [3:0] MB_C = 4'(MAX_BURST);

    // Circular search of valid starting at start; returns {found, index}.
    function automatic logic [2:0] rr_search(input logic [3:0] valid,
                                             input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from the farthest position back so the nearest hit wins.
        for (int k = 3; k >= 0; k--) begin
            idx = start + k[1:0];
            if (valid[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t        state_r, state_s;
    logic [1:0]    ptr_r, ptr_s;
    logic [1:0]    owner_r, owner_s;
    logic [3:0]    cnt_r, cnt_s;
    logic          out_valid_r, out_valid_s;
    logic [DW-1:0] out_data_r, out_data_s;
    logic [1:0]    out_src_r, out_src_s;
    logic          busy_r, busy_s;

    logic          ld_s;
    logic [1:0]    start_s;
    logic [2:0]    search_s;
    logic          grant_any_s;
    logic [1:0]    grant_idx_s;
    logic          new_win_s;
    logic [3:0]    req_ready_s;

    // Next-state, grant selection and output-register load decisions.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_src_s   = out_src_r;
        grant_any_s = 1'b0;
        grant_idx_s = 2'd0;
        new_win_s   = 1'b0;

        ld_s = ~out_valid_r | bus.out_ready;

        // A released lock searches from the slot after the old owner.
        if (state_r == LOCK) begin
            start_s = owner_r + 2'd1;
        end else begin
            start_s = ptr_r;
        end
        search_s = rr_search(bus.req_valid, start_s);

        if (ld_s) begin
            case (state_r)
                LOCK: begin
                    if (bus.req_valid[owner_r]) begin
                        grant_any_s = 1'b1;
                        grant_idx_s = owner_r;
                        if ((cnt_r + 4'd1) == MB_C) begin
                            state_s = IDLE;
                            ptr_s   = owner_r + 2'd1;
                            cnt_s   = 4'd0;
                        end else begin
                            cnt_s   = cnt_r + 4'd1;
                        end
                    end else begin
                        // Owner dropped out: hand over without a bubble beat.
                        ptr_s       = owner_r + 2'd1;
                        grant_any_s = search_s[2];
                        grant_idx_s = search_s[1:0];
                        new_win_s   = search_s[2];
                        state_s     = IDLE;
                        cnt_s       = 4'd0;
                    end
                end
                default: begin
                    grant_any_s = search_s[2];
                    grant_idx_s = search_s[1:0];
                    new_win_s   = search_s[2];
                end
            endcase

            if (new_win_s) begin
                if (MB_C == 4'd1) begin
                    state_s = IDLE;
                    ptr_s   = grant_idx_s + 2'd1;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = LOCK;
                    owner_s = grant_idx_s;
                    cnt_s   = 4'd1;
                end
            end else begin
                owner_s = owner_s;
            end

            if (grant_any_s) begin
                out_valid_s = 1'b1;
                out_data_s  = bus.req_data[32'(grant_idx_s)*DW +: DW];
                out_src_s   = grant_idx_s;
            end else begin
                out_valid_s = 1'b0;
            end
        end else begin
            out_valid_s = out_valid_r;
        end

        busy_s = (state_s == LOCK);
    end

    // Accept strobe back to the winning requester, silenced during reset.
    always_comb begin
        req_ready_s = 4'b0000;
        if (rst && ld_s && grant_any_s) begin
            req_ready_s = 4'b0001 << grant_idx_s;
        end else begin
            req_ready_s = 4'b0000;
        end
    end

    // State and output register slice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            owner_r     <= 2'd0;
            cnt_r       <= 4'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= 2'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_src_r   <= out_src_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: one instance with MAX_BURST=4 and
// one with MAX_BURST=1. Expected beats are queued by the stimulus and
// compared by per-instance monitors whenever a beat leaves the DUT.
module tb_rr_burst_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_burst_arbiter_if #(.DW(8)) bus4();
    rr_burst_arbiter_if #(.DW(8)) bus1();

    rr_burst_arbiter #(.DW(8), .MAX_BURST(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    rr_burst_arbiter #(.DW(8), .MAX_BURST(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
        logic       busy;
    } beat_t;

    beat_t exp4_q[$];
    beat_t exp1_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    // lanes a=10, b=26, c=14, d=9
    localparam logic [31:0] LANES = {8'd9, 8'd14, 8'd26, 8'd10};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int src, input int busy);
        beat_t b;
        logic [31:0] l;
        l = LANES;
        b.src  = src[1:0];
        b.data = l[8*src +: 8];
        b.busy = busy[0];
        return b;
    endfunction

    // Monitor for the MAX_BURST=4 instance: compare each beat as it is consumed.
    always @(negedge clk) begin
        beat_t e;
        if (rst && bus4.out_valid && bus4.out_ready) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL u4_unexpected_beat: got src=%0d data=%0d, none expected",
                         bus4.out_src, bus4.out_data);
            end else begin
                e = exp4_q.pop_front();
                check("u4_beat {src,data,busy}",
                      {21'd0, bus4.out_src, bus4.out_data, bus4.busy}, {21'd0, e});
            end
        end
    end

    // Monitor for the MAX_BURST=1 instance.
    always @(negedge clk) begin
        beat_t e;
        if (rst && bus1.out_valid && bus1.out_ready) begin
            if (exp1_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL u1_unexpected_beat: got src=%0d data=%0d, none expected",
                         bus1.out_src, bus1.out_data);
            end else begin
                e = exp1_q.pop_front();
                check("u1_beat {src,data,busy}",
                      {21'd0, bus1.out_src, bus1.out_data, bus1.busy}, {21'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus4.req_valid = 4'b1111;
        bus4.req_data  = LANES;
        bus4.out_ready = 1'b1;
        bus1.req_valid = 4'b1111;
        bus1.req_data  = LANES;
        bus1.out_ready = 1'b1;

        // Reset with every requester valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_u4_req_ready", {28'd0, bus4.req_ready}, 32'd0);
        check("rst_u4_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        check("rst_u4_out_data",  {24'd0, bus4.out_data},  32'd0);
        check("rst_u4_out_src",   {30'd0, bus4.out_src},   32'd0);
        check("rst_u4_busy",      {31'd0, bus4.busy},      32'd0);
        check("rst_u1_req_ready", {28'd0, bus1.req_ready}, 32'd0);
        check("rst_u1_out_valid", {31'd0, bus1.out_valid}, 32'd0);

        // Full contention, burst of 4 per requester
        for (int r = 0; r < 4; r++) begin
            exp4_q.push_back(mk(r, 1));
            exp4_q.push_back(mk(r, 1));
            exp4_q.push_back(mk(r, 1));
            exp4_q.push_back(mk(r, 0));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus1.req_valid = 4'b0000;
        @(negedge clk);
        check("u4_first_req_ready", {28'd0, bus4.req_ready}, 32'd1);
        repeat (16) @(posedge clk);
        #1 bus4.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("u4_contention_drop", {31'd0, bus4.out_valid}, 32'd0);
        check("u4_contention_busy", {31'd0, bus4.busy}, 32'd0);

        // Backpressure mid-burst (ptr=0)
        exp4_q.push_back(mk(0, 1));
        exp4_q.push_back(mk(0, 1));
        exp4_q.push_back(mk(0, 1));
        exp4_q.push_back(mk(0, 0));
        bus4.req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1 bus4.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, bus4.out_valid}, 32'd1);
            check("bp_out_data",  {24'd0, bus4.out_data},  32'd10);
            check("bp_out_src",   {30'd0, bus4.out_src},   32'd0);
            check("bp_req_ready", {28'd0, bus4.req_ready}, 32'd0);
            check("bp_busy",      {31'd0, bus4.busy},      32'd1);
        end
        bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus4.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("bp_drop", {31'd0, bus4.out_valid}, 32'd0);

        // Early release: requester 1 gives 2 beats, requester 2 follows at once
        exp4_q.push_back(mk(1, 1));
        exp4_q.push_back(mk(1, 1));
        exp4_q.push_back(mk(2, 1));
        exp4_q.push_back(mk(2, 1));
        exp4_q.push_back(mk(2, 1));
        exp4_q.push_back(mk(2, 0));
        bus4.req_valid = 4'b1110;
        repeat (2) @(posedge clk);
        #1 bus4.req_valid = 4'b1100;
        @(negedge clk);
        check("release_req_ready", {28'd0, bus4.req_ready}, 32'b0100);
        repeat (4) @(posedge clk);
        #1 bus4.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("release_drop", {31'd0, bus4.out_valid}, 32'd0);

        // Sparse / wrap (ptr=3)
        exp4_q.push_back(mk(3, 1));
        exp4_q.push_back(mk(0, 1));
        bus4.req_valid = 4'b1000;
        @(posedge clk);
        #1 bus4.req_valid = 4'b0001;
        @(posedge clk);
        #1 bus4.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("sparse_drop", {31'd0, bus4.out_valid}, 32'd0);
        // ptr=1 now: only requester 0 valid, reached by wrapping 1,2,3,0
        exp4_q.push_back(mk(0, 1));
        bus4.req_valid = 4'b0001;
        @(posedge clk);
        #1 bus4.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("wrap_drop", {31'd0, bus4.out_valid}, 32'd0);

        // MAX_BURST=1: one beat per requester per cycle
        for (int i = 0; i < 6; i++) begin
            exp1_q.push_back(mk(i % 4, 0));
        end
        bus1.req_valid = 4'b1111;
        repeat (6) @(posedge clk);
        #1 bus1.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("u1_drop", {31'd0, bus1.out_valid}, 32'd0);

        repeat (2) @(posedge clk);
        check("u4_queue_drained", exp4_q.size(), 32'd0);
        check("u1_queue_drained", exp1_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
